// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and sizing helpers for the bit-serial adder.
//   state_t     FSM state encoding (IDLE, RUN, DONE)
//   CNT_W       bit-counter width for the default operand width
//   cnt_width() bit-counter width for an arbitrary operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned CNT_W         = $clog2(WIDTH_DEFAULT);

  // Counter must hold WIDTH-1; at least one bit even for tiny widths.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: purely combinational 1-bit full adder.
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out (majority of a, b, ci)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add controller around a single full_adder_cell.
// Operands are accepted in IDLE over a valid/ready handshake, fed LSB-first
// through the cell one bit per clock (carry closed through a flip-flop), and
// the assembled sum/carry-out is offered on a valid/ready output port.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      synchronous active-low reset
//   IN_VALID   operand pair present on A, B, C_IN
//   IN_READY   high only in IDLE
//   A, B       WIDTH-bit operands
//   C_IN       carry-in
//   OUT_VALID  high only in DONE
//   OUT_READY  consumer accepts the result
//   SUM        registered sum, (A+B+C_IN) mod 2^WIDTH
//   C_OUT      carry-out of the MSB
//   OVF        signed overflow (only when SERIAL_ADD_OVF_EN is defined)
//
// Build option: define SERIAL_ADD_OVF_EN to add the OVF port and its logic.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh, b_sh, sum_q;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic              fa_s, fa_co;

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs depend only on state, so OUT_READY never reaches
  // IN_READY combinationally.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            a_sh    <= A;
            b_sh    <= B;
            carry_q <= C_IN;
            cnt_q   <= CNT_LAST;
          end
        end
        RUN: begin
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_co;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // On the final bit carry_q is the carry into the MSB and fa_co the carry out.
  always_ff @(posedge CLK) begin
    if (!RST_N)                         ovf_q <= 1'b0;
    else if (state_q == RUN && cnt_q == '0) ovf_q <= carry_q ^ fa_co;
  end

  assign OVF = ovf_q;
`endif

  assign SUM   = sum_q;
  assign C_OUT = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         CLK;
  logic         RST_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A, B;
  logic         C_IN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         C_OUT;
`ifdef SERIAL_ADD_OVF_EN
  logic         OVF;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .C_IN      (C_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .C_OUT     (C_OUT)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer addition, carry-out is bit W.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // Reference: signed overflow when like-signed operands yield an unlike-signed sum.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci);
    logic [W:0] r;
    r = ref_add(a, b, ci);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full transaction with the output held un-consumed for 'hold' cycles.
  task automatic do_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int unsigned hold);
    logic [W:0]  exp;
    logic        exp_ovf;
    int unsigned k;
    bit          ok;
    exp     = ref_add(a, b, ci);
    exp_ovf = ref_ovf(a, b, ci);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (IN_READY === 1'b1) begin ok = 1; break; end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s idle_wait: IN_READY=%b required 1", name, IN_READY);
      return;
    end
    A = a; B = b; C_IN = ci; IN_VALID = 1'b1; OUT_READY = 1'b0;
    tick();                         // accept edge
    IN_VALID = 1'b1;                // must be ignored from here on
    A = W'($urandom); B = W'($urandom); C_IN = 1'($urandom);
    k = 0;
    for (int i = 1; i <= int'(W) + 4; i++) begin
      tick();
      if (OUT_VALID === 1'b1) begin k = i; break; end
    end
    n_cmp++;
    if (k != W) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, k, W);
    end
    for (int h = 0; h <= int'(hold); h++) begin
      n_cmp++;
      if (SUM !== exp[W-1:0] || C_OUT !== exp[W] || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
        n_err++;
        $display("FAIL %s result[h=%0d]: SUM=%h C_OUT=%b OUT_VALID=%b IN_READY=%b required %h %b 1 0",
                 name, h, SUM, C_OUT, OUT_VALID, IN_READY, exp[W-1:0], exp[W]);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_cmp++;
      if (OVF !== exp_ovf) begin
        n_err++;
        $display("FAIL %s ovf[h=%0d]: OVF=%b required %b", name, h, OVF, exp_ovf);
      end
`endif
      if (h < int'(hold)) tick();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    n_cmp++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: IN_READY=%b OUT_VALID=%b required 1 0", name, IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0;
    A = 8'hAA; B = 8'h55; C_IN = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || SUM !== '0 || C_OUT !== 1'b0) begin
      n_err++;
      $display("FAIL reset: IN_READY=%b OUT_VALID=%b SUM=%h C_OUT=%b required 1 0 00 0",
               IN_READY, OUT_VALID, SUM, C_OUT);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: OVF=%b required 0", OVF);
    end
`endif
    IN_VALID = 1'b0;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    do_add("d_5a_3c", 8'h5A, 8'h3C, 1'b0, 0);
    do_add("d_ff_01", 8'hFF, 8'h01, 1'b0, 0);
    do_add("d_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0);
  endtask

  task automatic test_hold();
    do_add("hold5", 8'hC3, 8'h4E, 1'b1, 5);
  endtask

  task automatic test_reset_mid_run();
    A = 8'hA5; B = 8'h5A; C_IN = 1'b1; IN_VALID = 1'b1;
    tick();                         // accept
    IN_VALID = 1'b0;
    tick(); tick(); tick();         // RUN bits 0..2
    RST_N = 1'b0;
    tick();
    n_cmp++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || SUM !== '0 || C_OUT !== 1'b0) begin
      n_err++;
      $display("FAIL mid_run_reset: IN_READY=%b OUT_VALID=%b SUM=%h C_OUT=%b required 1 0 00 0",
               IN_READY, OUT_VALID, SUM, C_OUT);
    end
    RST_N = 1'b1;
    tick();
    do_add("after_reset", 8'h01, 8'h01, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      do_add("rand", W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    do_add("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1);
    do_add("ovf_80_80", 8'h80, 8'h80, 1'b0, 1);
    do_add("ovf_none", 8'h40, 8'h3F, 1'b0, 0);
  endtask
`endif

  task automatic test_back_to_back();
    logic [W:0]  exp_q[$];
    int          acc_q[$];
    int unsigned pushed, got;
    logic [W:0]  e;
    pushed = 0; got = 0;
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (OUT_VALID === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: OUT_VALID=1 with no pending operation");
        end else begin
          e = exp_q.pop_front();
          if (SUM !== e[W-1:0] || C_OUT !== e[W]) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: SUM=%h C_OUT=%b required %h %b",
                     got, SUM, C_OUT, e[W-1:0], e[W]);
          end
        end
        got++;
      end
      if (IN_READY === 1'b1) begin
        if (pushed < 4) begin
          A = W'($urandom); B = W'($urandom); C_IN = 1'($urandom);
          exp_q.push_back(ref_add(A, B, C_IN));
          acc_q.push_back(c + 1);
          pushed++;
        end else begin
          IN_VALID = 1'b0;
        end
      end
      if (got == 4) break;
      tick();
    end
    n_cmp++;
    if (got != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results required 4", got);
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      n_cmp++;
      if (acc_q[i] - acc_q[i-1] != int'(W) + 2) begin
        n_err++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                 i, acc_q[i] - acc_q[i-1], W + 2);
      end
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    tick();
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; C_IN = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
